// File: rtl/secuenciador_fir_pkg.sv
// Shared constants for the FIR sequencer: widths, tap count,
// FSM encoding and saturation limits.
package secuenciador_fir_pkg;
  localparam int N    = 25;
  localparam int FRAC = 10;
  localparam int TAPS = 4;
  localparam int AW   = $clog2(TAPS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic signed [N-1:0] SAT_MAX =
    {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SAT_MIN =
    {1'b1, {(N-1){1'b0}}};
endpackage

// File: rtl/secuenciador_fir_if.sv
// Sample, coefficient and result handshake bundle of the
// FIR sequencer.
interface secuenciador_fir_if #(
  parameter int N  = secuenciador_fir_pkg::N,
  parameter int AW = secuenciador_fir_pkg::AW
);
  logic [N-1:0]  dato_in;
  logic          dato_valid;
  logic          dato_listo;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [N-1:0]  coef_data;
  logic [N-1:0]  dato_out;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;

  modport master (
    output dato_in, dato_valid, coef_we,
    output coef_addr, coef_data, out_ready,
    input  dato_listo, dato_out, out_valid, overflow
  );

  modport slave (
    input  dato_in, dato_valid, coef_we,
    input  coef_addr, coef_data, out_ready,
    output dato_listo, dato_out, out_valid, overflow
  );
endinterface

// File: rtl/secuenciador_fir_truncador_sat.sv
// Rescales a Q(2*FRAC) value to Q(FRAC) with an arithmetic
// shift and clamps it to the N-bit two's complement range.
module truncador_sat #(
  parameter int N    = secuenciador_fir_pkg::N,
  parameter int FRAC = secuenciador_fir_pkg::FRAC,
  parameter logic signed [N-1:0] SMAX =
    secuenciador_fir_pkg::SAT_MAX,
  parameter logic signed [N-1:0] SMIN =
    secuenciador_fir_pkg::SAT_MIN
) (
  input  logic signed [2*N-1:0] valor,
  output logic signed [N-1:0]   dato,
  output logic                  clamp
);
  localparam logic signed [2*N-1:0] HI =
    {{N{SMAX[N-1]}}, SMAX};
  localparam logic signed [2*N-1:0] LO =
    {{N{SMIN[N-1]}}, SMIN};

  logic signed [2*N-1:0] sh;

  always_comb begin
    sh    = valor >>> FRAC;
    dato  = sh[N-1:0];
    clamp = 1'b0;
    if (sh > HI) begin
      dato  = SMAX;
      clamp = 1'b1;
    end else if (sh < LO) begin
      dato  = SMIN;
      clamp = 1'b1;
    end
  end
endmodule

// File: rtl/secuenciador_fir.sv
// FIR tap sequencer: walks the delay line and coefficients
// through an external multiply-accumulate stage.
module secuenciador_fir #(
  parameter int N    = secuenciador_fir_pkg::N,
  parameter int FRAC = secuenciador_fir_pkg::FRAC,
  parameter int TAPS = secuenciador_fir_pkg::TAPS
) (
  input  logic                  clk,
  input  logic                  reset,
  secuenciador_fir_if.slave     bus,
  output logic signed [N-1:0]   Constantes_G,
  output logic signed [N-1:0]   Multip_G,
  output logic signed [N-1:0]   Entrada_G,
  input  logic signed [2*N-1:0] Valores
);
  import secuenciador_fir_pkg::*;

  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic [1:0]          state;
  logic signed [N-1:0] coef  [TAPS];
  logic signed [N-1:0] linea [TAPS];
  logic signed [N-1:0] acc;
  logic [AW-1:0]       tap;
  logic                ovf;
  logic signed [N-1:0] sat_val;
  logic                sat_clamp;
  logic                en_mac;
  logic                en_done;

  assign en_mac  = (state == MAC);
  assign en_done = (state == DONE);

  truncador_sat #(
    .N    (N),
    .FRAC (FRAC),
    .SMAX ({1'b0, {(N-1){1'b1}}}),
    .SMIN ({1'b1, {(N-1){1'b0}}})
  ) u_sat (
    .valor (Valores),
    .dato  (sat_val),
    .clamp (sat_clamp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      tap   <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        coef[i]  <= '0;
        linea[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          // write lands at the accepting edge, so the new
          // coefficient is already in place for this sample
          if (bus.coef_we) begin
            for (int i = 0; i < TAPS; i++) begin
              if (bus.coef_addr == AW'(i))
                coef[i] <= bus.coef_data;
            end
          end
          if (bus.dato_valid) begin
            linea[0] <= bus.dato_in;
            for (int i = 1; i < TAPS; i++)
              linea[i] <= linea[i-1];
            acc   <= '0;
            tap   <= '0;
            ovf   <= 1'b0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= sat_val;
          ovf <= ovf | sat_clamp;
          tap <= tap + AW'(1);
          if (tap == AW'(TAPS-1))
            state <= DONE;
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Constantes_G = en_mac ? coef[tap]  : '0;
  assign Multip_G     = en_mac ? linea[tap] : '0;
  assign Entrada_G    = en_mac ? acc        : '0;

  assign bus.dato_listo = (state == IDLE);
  assign bus.out_valid  = en_done;
  assign bus.dato_out   = en_done ? acc : '0;
  assign bus.overflow   = en_done & ovf;
endmodule
